led_cmd_ctrl: RTL

Command executor sitting directly downstream of `spi_slave`: consumes each decoded frame (cmd/addr/payload), maintains brightness registers for the four Zybo LEDs, and drives them with PWM. It also builds the response frame that `spi_slave` shifts back on MISO during the next transaction, for read-back and error reporting.

---
 rtl/led_cmd_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/led_cmd_ctrl.sv
// Executes SET/GET/CLR frames from spi_slave on the LED brightness registers, drives PWM
// and builds the MISO response. Define LED_CTRL_SOFT_RAMP_EN to step duty by 1% per period.
module led_cmd_ctrl #(
  parameter int PRESCALE           = 1250,
  parameter int N_LEDS             = 4,
  parameter int CMD_BITS           = 8,
  parameter int ADDR_BITS          = 8,
  parameter int PAYLOAD_BITS       = 8,
  parameter int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + 8
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          i_frame_vld,
  input  logic [CMD_BITS-1:0]           i_cmd,
  input  logic [ADDR_BITS-1:0]          i_addr,
  input  logic [PAYLOAD_BITS-1:0]       i_payload,
  output logic [MASTER_FRAME_WIDTH-1:0] o_rsp_frame,
  output logic                          o_rsp_vld,
  output logic                          o_slv_tx_enb,
  output logic [N_LEDS-1:0]             o_led,
  output logic [7:0]                    o_err_cnt
);

  localparam logic [CMD_BITS-1:0] CMD_LED_SET = CMD_BITS'(8'h01);
  localparam logic [CMD_BITS-1:0] CMD_LED_GET = CMD_BITS'(8'h02);
  localparam logic [CMD_BITS-1:0] CMD_LED_CLR = CMD_BITS'(8'h03);
  localparam logic [CMD_BITS-1:0] CMD_ERR     = CMD_BITS'(8'hEE);
  localparam int IDX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [CMD_BITS-1:0]             r_cmd;
  logic [ADDR_BITS-1:0]            r_addr;
  logic [PAYLOAD_BITS-1:0]         r_payload;
  logic                            r_ok;
  logic [6:0]                      r_target [N_LEDS];
  logic [6:0]                      r_active [N_LEDS];
  logic [MASTER_FRAME_WIDTH-1:0]   r_rsp_frame;
  logic                            r_rsp_vld;
  logic                            r_tx_enb;
  logic [7:0]                      r_err_cnt;
  logic [PS_W-1:0]                 r_presc;
  logic [6:0]                      r_pwm_cnt;
  logic [N_LEDS-1:0]               r_led;

  logic [IDX_W-1:0]                w_idx;
  logic                            w_cmd_known;
  logic                            w_addr_ok;
  logic [6:0]                      w_clamped;
  logic [7:0]                      w_err_inc1;
  logic [1:0]                      w_err_add;
  logic [8:0]                      w_err_sum;
  logic [7:0]                      w_err_next;
  logic [CMD_BITS-1:0]             w_rsp_cmd;
  logic [7:0]                      w_rsp_data;
  logic                            w_tick;
  logic                            w_wrap;

  assign w_idx       = r_addr[IDX_W-1:0];
  assign w_cmd_known = (r_cmd == CMD_LED_SET) || (r_cmd == CMD_LED_GET) || (r_cmd == CMD_LED_CLR);
  assign w_addr_ok   = (r_addr < ADDR_BITS'(N_LEDS));
  assign w_clamped   = (r_payload > PAYLOAD_BITS'(100)) ? 7'd100 : r_payload[6:0];

  // Overrun and an error response can land in the same cycle; both are counted.
  assign w_err_inc1 = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
  assign w_err_add  = {1'b0, (i_frame_vld && (r_state != S_IDLE))} +
                      {1'b0, ((r_state == S_RESP) && !r_ok)};
  assign w_err_sum  = {1'b0, r_err_cnt} + {7'd0, w_err_add};
  assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  always_ff @(posedge sysclk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_frame_vld) w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_rsp_cmd  = r_cmd;
    w_rsp_data = 8'h00;
    if (!r_ok) begin
      w_rsp_cmd  = CMD_ERR;
      w_rsp_data = w_err_inc1;
    end else if (r_cmd == CMD_LED_SET) begin
      w_rsp_data = {1'b0, w_clamped};
    end else if (r_cmd == CMD_LED_GET) begin
      w_rsp_data = {1'b0, r_target[w_idx]};
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_addr      <= '0;
      r_payload   <= '0;
      r_ok        <= 1'b0;
      r_rsp_frame <= '0;
      r_rsp_vld   <= 1'b0;
      r_tx_enb    <= 1'b0;
      r_err_cnt   <= '0;
      for (int i = 0; i < N_LEDS; i++) r_target[i] <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      r_err_cnt <= w_err_next;
      if ((r_state == S_IDLE) && i_frame_vld) begin
        r_cmd     <= i_cmd;
        r_addr    <= i_addr;
        r_payload <= i_payload;
      end
      if (r_state == S_DECODE) r_ok <= w_cmd_known && w_addr_ok;
      if ((r_state == S_EXEC) && r_ok) begin
        if (r_cmd == CMD_LED_SET) begin
          r_target[w_idx] <= w_clamped;
        end else if (r_cmd == CMD_LED_CLR) begin
          for (int i = 0; i < N_LEDS; i++) r_target[i] <= '0;
        end
      end
      // Response stays armed for exactly one SPI transaction.
      if (r_state == S_RESP) begin
        r_rsp_frame <= {w_rsp_cmd, r_addr, w_rsp_data};
        r_rsp_vld   <= 1'b1;
        r_tx_enb    <= 1'b1;
      end else if (i_frame_vld) begin
        r_tx_enb    <= 1'b0;
      end
    end
  end

  assign w_tick = (r_presc == PS_W'(PRESCALE - 1));
  assign w_wrap = w_tick && (r_pwm_cnt == 7'd99);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_led     <= '0;
      for (int i = 0; i < N_LEDS; i++) r_active[i] <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      if (w_tick) r_pwm_cnt <= (r_pwm_cnt == 7'd99) ? 7'd0 : r_pwm_cnt + 7'd1;
      for (int i = 0; i < N_LEDS; i++) begin
        // Duty only changes at period wrap so a period is never cut short.
        if (w_wrap) begin
`ifdef LED_CTRL_SOFT_RAMP_EN
          if (r_active[i] < r_target[i])      r_active[i] <= r_active[i] + 7'd1;
          else if (r_active[i] > r_target[i]) r_active[i] <= r_active[i] - 7'd1;
`else
          r_active[i] <= r_target[i];
`endif
        end
        r_led[i] <= (r_pwm_cnt < r_active[i]);
      end
    end
  end

  assign o_rsp_frame  = r_rsp_frame;
  assign o_rsp_vld    = r_rsp_vld;
  assign o_slv_tx_enb = r_tx_enb;
  assign o_led        = r_led;
  assign o_err_cnt    = r_err_cnt;

endmodule
